// File: rtl/sram16_ctrl_pkg.sv
// Shared types for the 16-bit asynchronous SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} sram_state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram16_ctrl.sv
// Splits 32-bit bus requests into two 16-bit SRAM phases with registered,
// glitch-free strobes and returns a one-cycle response pulse.
module sram16_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  inout  wire  [15:0]       sram_data
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

  sram_state_t       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              lat_we, we_d;
  logic [ADDR_W-2:0] lat_widx, widx_d;
  logic [31:0]       lat_wdata, wdata_d;
  logic [3:0]        lat_wstrb, wstrb_d;
  logic [15:0]       rdata_lo;
  logic              phase_end;
  logic              half;

  logic [ADDR_W-1:0] addr_d;
  logic              ce_d, we_n_d, oe_d, ub_d, lb_d, drive_d, drive_q;
  logic [15:0]       dout_d, dout_q;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

  // Next state plus the strobe image of that next state, so every SRAM pin is a flop output.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    we_d      = lat_we;
    widx_d    = lat_widx;
    wdata_d   = lat_wdata;
    wstrb_d   = lat_wstrb;
    phase_end = (cnt == CNT_MAX);
    case (state)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          widx_d  = req_addr[ADDR_W:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = '0;
          if (!req_we || req_wstrb[1:0] != 2'b00)
            state_d = LO;
          else if (req_wstrb[3:2] != 2'b00)
            state_d = HI;
          else
            state_d = RESP;
        end
      end
      LO: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = (!lat_we || lat_wstrb[3:2] != 2'b00) ? HI : RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HI: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    half    = (state_d == HI) ? HALF_HI : HALF_LO;
    addr_d  = sram_addr;
    ce_d    = 1'b1;
    we_n_d  = 1'b1;
    oe_d    = 1'b1;
    ub_d    = 1'b1;
    lb_d    = 1'b1;
    drive_d = 1'b0;
    dout_d  = dout_q;
    if (state_d == LO || state_d == HI) begin
      addr_d = {widx_d, half};
      ce_d   = 1'b0;
      if (we_d) begin
        we_n_d  = 1'b0;
        drive_d = 1'b1;
        ub_d    = half ? ~wstrb_d[3] : ~wstrb_d[1];
        lb_d    = half ? ~wstrb_d[2] : ~wstrb_d[0];
        dout_d  = half ? wdata_d[31:16] : wdata_d[15:0];
      end else begin
        oe_d = 1'b0;
        ub_d = 1'b0;
        lb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_widx   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      rdata_lo   <= '0;
      resp_rdata <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      drive_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      lat_we    <= we_d;
      lat_widx  <= widx_d;
      lat_wdata <= wdata_d;
      lat_wstrb <= wstrb_d;
      sram_addr <= addr_d;
      sram_ce_n <= ce_d;
      sram_we_n <= we_n_d;
      sram_oe_n <= oe_d;
      sram_ub_n <= ub_d;
      sram_lb_n <= lb_d;
      drive_q   <= drive_d;
      dout_q    <= dout_d;
      // The HI capture edge is also the RESP entry edge, so the word is assembled here.
      if (state == LO && phase_end && !lat_we)
        rdata_lo <= sram_data;
      if (state == HI && phase_end && !lat_we)
        resp_rdata <= {sram_data, rdata_lo};
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign sram_data  = drive_q ? dout_q : 16'hzzzz;

endmodule

// File: tb/tb_sram16_ctrl.sv
// Drives two controllers (WAIT_CYCLES 0 and 2) against behavioural SRAMs and
// checks every cycle of each transaction against a word-level reference model.
module tb_sram16_ctrl;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        valid0, valid2;
  logic        ready0, ready2, rv0, rv2;
  logic [31:0] rdata0, rdata2;
  logic [AW-1:0] sa0, sa2;
  logic        ce0, we0, oe0, ub0, lb0;
  logic        ce2, we2, oe2, ub2, lb2;
  wire  [15:0] sd0, sd2;

  logic [15:0] mem0 [0:(1<<AW)-1];
  logic [15:0] mem2 [0:(1<<AW)-1];
  logic [31:0] ref_mem [2][16];
  logic [31:0] last_rd [2];

  int n_cmp = 0;
  int n_bad = 0;
  int sel = 0;

  sram16_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(rv0), .resp_rdata(rdata0), .sram_addr(sa0), .sram_ce_n(ce0),
    .sram_we_n(we0), .sram_oe_n(oe0), .sram_ub_n(ub0), .sram_lb_n(lb0), .sram_data(sd0)
  );

  sram16_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_ready(ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(rv2), .resp_rdata(rdata2), .sram_addr(sa2), .sram_ce_n(ce2),
    .sram_we_n(we2), .sram_oe_n(oe2), .sram_ub_n(ub2), .sram_lb_n(lb2), .sram_data(sd2)
  );

  // Asynchronous SRAM behaviour: drive on read, latch enabled bytes on write.
  assign sd0 = (!ce0 && !oe0 && we0) ? mem0[sa0] : 16'hzzzz;
  assign sd2 = (!ce2 && !oe2 && we2) ? mem2[sa2] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce0 && !we0) begin
      if (!lb0) mem0[sa0][7:0]  <= sd0[7:0];
      if (!ub0) mem0[sa0][15:8] <= sd0[15:8];
    end
    if (!ce2 && !we2) begin
      if (!lb2) mem2[sa2][7:0]  <= sd2[7:0];
      if (!ub2) mem2[sa2][15:8] <= sd2[15:8];
    end
  end

  wire          c_ready = (sel != 0) ? ready2 : ready0;
  wire          c_rv    = (sel != 0) ? rv2 : rv0;
  wire [31:0]   c_rdata = (sel != 0) ? rdata2 : rdata0;
  wire [AW-1:0] c_addr  = (sel != 0) ? sa2 : sa0;
  wire [15:0]   c_data  = (sel != 0) ? sd2 : sd0;
  wire [4:0]    c_strb  = (sel != 0) ? {ce2, we2, oe2, ub2, lb2} : {ce0, we0, oe0, ub0, lb0};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One complete request on controller s; every cycle until the response is checked.
  task automatic applyStimulus(input int s, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    int w, nph, total, p;
    int ph [2];
    logic hb;
    logic [31:0] exp;
    logic [3:0] idx;
    w   = (s != 0) ? 2 : 0;
    idx = addr[5:2];
    exp = ref_mem[s][idx];
    nph = 0;
    if (!we || wstrb[1:0] != 2'b00) begin ph[nph] = 0; nph++; end
    if (!we || wstrb[3:2] != 2'b00) begin ph[nph] = 1; nph++; end
    total = nph * (w + 1) + 1;

    @(negedge clk);
    sel = s;
    checkOutput("idle_ready", c_ready, 1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    if (s != 0) valid2 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      valid0 = 1'b0;
      valid2 = 1'b0;
      if (k < total) begin
        p  = (k - 1) / (w + 1);
        hb = (ph[p] != 0);
        checkOutput("phase_addr", c_addr, {addr[AW:2], hb});
        if (we) begin
          checkOutput("wr_strobes", c_strb,
                      {3'b001, hb ? ~wstrb[3] : ~wstrb[1], hb ? ~wstrb[2] : ~wstrb[0]});
          checkOutput("wr_bus", c_data, hb ? wdata[31:16] : wdata[15:0]);
        end else begin
          checkOutput("rd_strobes", c_strb, 5'b01000);
          checkOutput("rd_bus", c_data, hb ? exp[31:16] : exp[15:0]);
        end
        checkOutput("busy_resp", c_rv, 0);
        checkOutput("busy_ready", c_ready, 0);
      end else begin
        checkOutput("resp_valid", c_rv, 1);
        checkOutput("resp_strobes", c_strb, 5'h1f);
        checkOutput("resp_rdata", c_rdata, we ? last_rd[s] : exp);
      end
    end

    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[s][idx][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      last_rd[s] = exp;
    end
  endtask

  initial begin
    logic [31:0] a, b_exp;
    for (int i = 0; i < (1 << AW); i++) begin
      mem0[i] = '0;
      mem2[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst = 1'b1; valid0 = 1'b0; valid2 = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      checkOutput("rst_ready", c_ready, 1);
      checkOutput("rst_resp", c_rv, 0);
      checkOutput("rst_rdata", c_rdata, 0);
      checkOutput("rst_addr", c_addr, 0);
      checkOutput("rst_strobes", c_strb, 5'h1f);
    end
    rst = 1'b0;

    // Directed sequence on the zero-wait controller.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);
    applyStimulus(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);
    checkOutput("byte_merge", last_rd[0], 32'hDEAABEEF);
    applyStimulus(0, 1'b1, 32'h14, 32'h12345678, 4'h0);
    applyStimulus(0, 1'b1, 32'h14, 32'hCAFEF00D, 4'b0011);
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 4'hF);

    // Reset during the LO phase of a write.
    @(negedge clk);
    sel = 0;
    req_we = 1'b1; req_addr = 32'h400; req_wdata = 32'h55AA33CC; req_wstrb = 4'hF;
    valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    checkOutput("abort_lo_strobes", c_strb, 5'b00100);
    rst = 1'b1;
    #1;
    checkOutput("abort_strobes", c_strb, 5'h1f);
    checkOutput("abort_resp", c_rv, 0);
    checkOutput("abort_ready", c_ready, 1);
    checkOutput("abort_addr", c_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", c_rv, 0);
      checkOutput("abort_idle_ready", c_ready, 1);
    end

    // Multi-cycle phases on the WAIT_CYCLES=2 controller.
    applyStimulus(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 32'h10, 32'h00AA0000, 4'b0100);
    applyStimulus(1, 1'b1, 32'h20, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0);

    // Back-to-back reads with req_valid held.
    @(negedge clk);
    sel = 0;
    checkOutput("b2b_ready0", c_ready, 1);
    req_we = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0; valid0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_addr = 32'h14;
      if (k == 5) valid0 = 1'b0;
      checkOutput("b2b_we_oe_excl", {31'd0, we0 | oe0}, 1);
      checkOutput("b2b_ready", c_ready, (k == 4) ? 1 : 0);
      checkOutput("b2b_resp", c_rv, (k == 3 || k == 7) ? 1 : 0);
      if (k == 3) checkOutput("b2b_rdata_a", c_rdata, ref_mem[0][4]);
      if (k == 7) checkOutput("b2b_rdata_b", c_rdata, ref_mem[0][5]);
    end
    last_rd[0] = ref_mem[0][5];

    // Randomized traffic with aliased upper address bits.
    for (int t = 0; t < 300; t++) begin
      a = {14'($urandom), 12'd0, 4'($urandom), 2'($urandom)};
      b_exp = $urandom;
      applyStimulus(int'($urandom_range(0, 1)), 1'($urandom), a, b_exp, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram16_ctrl.md
Name: sram16_ctrl

Overview:
- Bus-side controller that sits directly upstream of the board's 16-bit asynchronous SRAM (IS61WV12816-style pins: active-low CE/WE/OE/UB/LB, bidirectional 16-bit data).
- Accepts 32-bit word requests from the CPU data path with byte strobes.
- Splits each request into low-half and high-half SRAM phases with registered, glitch-free strobes.
- Returns a one-cycle response pulse carrying read data or a write acknowledge.

Parameters:
- ADDR_W, 17: SRAM halfword address width.
- WAIT_CYCLES, 0: extra cycles per SRAM phase. Each phase lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted when valid&&ready at posedge.
- req_we  in  1  1=write, 0=read.
- req_addr  in  32  byte address; [1:0] ignored; [31:ADDR_W+1] ignored (aliasing).
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables for writes; ignored on reads.
- resp_valid  out  1  one-cycle pulse at request completion; no backpressure.
- resp_rdata  out  32  read data; holds its value until the next read completes.
- sram_addr  out  ADDR_W  halfword address.
- sram_ce_n / sram_we_n / sram_oe_n / sram_ub_n / sram_lb_n  out  1 each  active-low strobes.
- sram_data  inout  16  SRAM data bus.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; sram_addr=0.
  - All sram_*_n=1; sram_data=Z.
  - A reset mid-operation aborts immediately and issues no response. A LO half already written stays written.
- FSM states: IDLE, LO, HI, RESP.
  - IDLE, on accept: latch we/addr/wdata/wstrb.
    - Read goes to LO.
    - Write goes to LO if wstrb[1:0]!=0, else to HI if wstrb[3:2]!=0, else to RESP (empty write).
  - LO: sram_addr={addr[ADDR_W:2],1'b0}.
    - Write: ub_n=~wstrb[1], lb_n=~wstrb[0], data=wdata[15:0].
    - After WAIT_CYCLES+1 cycles: a read or a write with wstrb[3:2]!=0 goes to HI; otherwise to RESP.
  - HI: sram_addr={addr[ADDR_W:2],1'b1}.
    - Write: ub_n=~wstrb[3], lb_n=~wstrb[2], data=wdata[31:16].
    - After WAIT_CYCLES+1 cycles goes to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Strobe levels in phases:
  - Read phases: ce_n=0, oe_n=0, we_n=1, ub_n=lb_n=0.
  - Write phases: ce_n=0, we_n=0, oe_n=1.
  - Outside LO/HI all strobes are 1.
- Read sampling: sram_data is captured at the posedge ending each read phase, into rdata[15:0] (LO) or rdata[31:16] (HI). resp_rdata updates on entry to RESP.
- Write timing: the SRAM samples at the posedge ending each write phase.
- Bus drive rules:
  - sram_data is driven only while state∈{LO,HI} && we_n=0; otherwise Z.
  - oe_n=0 and we_n=0 are never asserted together.
- Phase counter: 0..WAIT_CYCLES, cleared on every phase entry.
- Latency: resp_valid is high N*(WAIT_CYCLES+1)+1 cycles after the accept edge, where N is the number of executed phases (0..2).
- req_ready=1 only in IDLE. req_valid held during busy states is ignored until the controller returns to IDLE.
- All strobe/address outputs come from registers: no combinational path from req_* to sram_*.

Decomposition:
- sram_pkg holds:
  - typedef enum sram_state_t {IDLE,LO,HI,RESP};
  - localparams HALF_LO=1'b0, HALF_HI=1'b1.
- Single module, no sub-module. The phase counter is inline.

Test Plan:
- Reset mid-write: assert rst during the LO phase of a write → all strobes go 1 and sram_data goes Z within the same cycle (async), no resp_valid, req_ready=1 after release.
- Full write, WAIT_CYCLES=0: addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF →
  - LO: sram_addr=0x00008, data 0xBEEF, ub_n=lb_n=0.
  - HI: sram_addr=0x00009, data 0xDEAD.
  - resp_valid 3 cycles after accept.
- Read of addr=0x10 → both phases with oe_n=0 and sram_data=Z from the controller; resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
- Byte write: addr=0x10, wdata=0x00AA0000, wstrb=4'b0100 → LO skipped, HI with lb_n=0 and ub_n=1, resp after 2 cycles; readback=0xDEAABEEF. Also an empty write with wstrb=0 → resp after 1 cycle and no SRAM strobe.
- WAIT_CYCLES=2 read → each phase held 3 cycles with stable addr/strobes, resp_valid 7 cycles after accept.
- Back-to-back: req_valid held high with a second read → req_ready=0 from accept until the RESP cycle; the second request is accepted in the following IDLE cycle; we_n and oe_n are never both 0.
